// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, condition codes, branch/cmov condition, E/M pipeline register
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   E_stat/E_icode/E_ifun         decoded instruction from the E register
//   E_valC/E_valA/E_valB          immediate and operand values
//   E_dstE/E_dstM                 destination register IDs (4'hF = none)
//   m_stat/W_stat                 downstream status; an exception there blocks the flag update
//   M_bubble                      loads a NOP bubble into the M register
//   e_valE/e_dstE/e_Cnd           combinational forwarding outputs
//   cc                            registered {ZF,SF,OF}
//   M_*                           registered E/M pipeline register

module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [2:0]  cc,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alufun;
    logic        new_zf;
    logic        new_sf;
    logic        new_of;
    logic        set_cc;
    logic        m_err;
    logic        w_err;
    logic        zf;
    logic        sf;
    logic        of;

    always_comb begin
        alu_a = 64'd0;
        case (E_icode)
            I_CMOVXX, I_OPQ:                alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = E_valC;
            I_CALL, I_PUSHQ:                alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:                  alu_a = 64'd8;
            default:                        alu_a = 64'd0;
        endcase
    end

    always_comb begin
        alu_b = 64'd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
            default:                                                    alu_b = 64'd0;
        endcase
    end

    assign alufun = (E_icode == I_OPQ) ? E_ifun : A_ADD;

    always_comb begin
        e_valE = 64'd0;
        new_of = 1'b0;
        case (alufun)
            A_ADD: begin
                e_valE = alu_b + alu_a;
                new_of = (alu_a[63] == alu_b[63]) && (e_valE[63] != alu_a[63]);
            end
            A_SUB: begin
                e_valE = alu_b - alu_a;
                new_of = (alu_a[63] != alu_b[63]) && (e_valE[63] != alu_b[63]);
            end
            A_AND:   e_valE = alu_b & alu_a;
            A_XOR:   e_valE = alu_b ^ alu_a;
            default: e_valE = 64'd0;
        endcase
    end

    assign new_zf = (e_valE == 64'd0);
    assign new_sf = e_valE[63];

    // An exception already further down the pipe must not let a younger OPQ change the flags.
    assign m_err  = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign w_err  = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
    assign set_cc = (E_icode == I_OPQ) && !m_err && !w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= 3'b100;
        end else if (set_cc) begin
            cc <= {new_zf, new_sf, new_of};
        end
    end

    // Conditions read the committed flags, never the flags being produced this cycle.
    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (sf ^ of) | zf;
            4'h2:    e_Cnd = sf ^ of;
            4'h3:    e_Cnd = zf;
            4'h4:    e_Cnd = ~zf;
            4'h5:    e_Cnd = ~(sf ^ of);
            4'h6:    e_Cnd = ~(sf ^ of) & ~zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    // A conditional move that is not taken writes nowhere.
    assign e_dstE = ((E_icode == I_CMOVXX) && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_stat  <= S_AOK;
            M_icode <= I_NOP;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
            M_Cnd   <= 1'b0;
            M_valE  <= 64'd0;
            M_valA  <= 64'd0;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
        end
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-003 SHALL have ports E_stat, E_icode, E_ifun, input, 4 each, decoded instruction status, code and function from the E register.
REQ-004 SHALL have ports E_valC, E_valA, E_valB, input, 64 each, the immediate and the two operand values.
REQ-005 SHALL have ports E_dstE, E_dstM, input, 4 each, destination register IDs (4'hF = RNONE).
REQ-006 SHALL have ports m_stat and W_stat, input, 4 each, downstream status used to suppress CC update.
REQ-007 SHALL have port M_bubble, input, 1, loads a bubble into the M register.
REQ-008 SHALL have ports e_valE (output, 64), e_dstE (output, 4) and e_Cnd (output, 1), combinational forwarding outputs.
REQ-009 SHALL have port cc, output, 3, registered {ZF,SF,OF}.
REQ-010 SHALL have ports M_stat, M_icode, M_dstE, M_dstM (output, 4 each), M_Cnd (output, 1), M_valE and M_valA (output, 64 each), the registered E/M pipeline register.

Function
REQ-011 SHALL use these encodings: icode HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B; stat AOK 1, HLT 2, ADR 3, INS 4.
REQ-012 SHALL select aluA as follows: E_valA for CMOVXX and OPQ; E_valC for IRMOVQ, RMMOVQ and MRMOVQ; -8 for CALL and PUSHQ; +8 for RET and POPQ; 0 otherwise.
REQ-013 SHALL select aluB as follows: E_valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET and POPQ; 0 otherwise.
REQ-014 SHALL select alufun: E_ifun when icode is OPQ, else ADD.
REQ-015 SHALL compute e_valE by alufun: 0 ADD = B+A; 1 SUB = B-A; 2 AND = B&A; 3 XOR = B^A; ifun 4-F yields 0.
REQ-016 SHALL do all arithmetic modulo 2^64; the carry-out is discarded.
REQ-017 SHALL compute the new flags as: ZF = (e_valE==0); SF = e_valE[63].
REQ-018 SHALL compute OF per operation:
- ADD: A[63]==B[63] and result[63]!=A[63].
- SUB: A[63]!=B[63] and result[63]!=B[63].
- AND/XOR: 0.
REQ-019 SHALL assert set_cc only when all hold:
- icode==OPQ;
- m_stat not in {HLT,ADR,INS};
- W_stat not in {HLT,ADR,INS}.
REQ-020 SHALL load cc on the clk edge when set_cc is 1, and hold cc otherwise; latency from OPQ in E to visible cc is 1 cycle.
REQ-021 SHALL evaluate e_Cnd combinationally from the registered cc (not from the same-cycle new flags) by E_ifun:
- 0: 1.
- 1: (SF^OF)|ZF.
- 2: SF^OF.
- 3: ZF.
- 4: ~ZF.
- 5: ~(SF^OF).
- 6: ~(SF^OF)&~ZF.
- 7-F: 0.
REQ-022 SHALL drive e_dstE = RNONE when icode==CMOVXX and e_Cnd==0, else E_dstE.
REQ-023 SHALL, on each clk edge without rst or M_bubble, load the M register as follows:
- M_stat/icode/dstM/valA from E;
- M_Cnd from e_Cnd;
- M_valE from e_valE;
- M_dstE from e_dstE.
REQ-024 SHALL, when M_bubble=1, load the M register with: stat AOK, icode NOP, dstE F, dstM F, Cnd 0, valE 0, valA 0. cc still updates if set_cc.
REQ-025 SHALL give rst priority over M_bubble and over set_cc when they coincide.

Reset
REQ-026 SHALL, on rst, set cc = 3'b100 (ZF=1, SF=0, OF=0) and the M register to the bubble values of REQ-024.
REQ-027 SHALL, when rst is asserted mid-operation, discard the in-flight E values; the next non-reset edge loads normally.

Verification
REQ-028 SHALL cover: OPQ ADD with A=7FFF_FFFF_FFFF_FFFF and B=1 -> valE=8000_0000_0000_0000; next cycle cc=3'b011.
REQ-029 SHALL cover: OPQ SUB with A=5 and B=5 -> valE=0; next cycle cc=3'b100; a following JXX ifun 3 gives e_Cnd=1.
REQ-030 SHALL cover: OPQ XOR with A=FF00 and B=0F0F -> valE=F00F; next cycle cc=3'b000; OF stays 0.
REQ-031 SHALL cover: OPQ ADD with m_stat=ADR -> valE is still computed; cc is unchanged.
REQ-032 SHALL cover: cc=3'b000, CMOVXX ifun 1 (le), E_dstE=3 -> e_dstE=F, M_Cnd=0.
REQ-033 SHALL cover: M_bubble=1 together with valid OPQ ADD -> M_icode=1, M_dstE=F; cc updated; rst in the same cycle -> cc=3'b100.
